// File: rtl/cmp_seq_ctrl.sv
// Nibble-serial wide magnitude compare that time-shares one external 4-bit
// comparator slice. It walks LSB to MSB and feeds the slice result back as cascade.
module cmp_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic                   START,
  input  logic [4*NIBBLES-1:0]   A,
  input  logic [4*NIBBLES-1:0]   B,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   QAGB,
  output logic                   QASB,
  output logic                   QAEB,
  output logic                   ERR,
  output logic [3:0]             CA,
  output logic [3:0]             CB,
  output logic                   CIAGB,
  output logic                   CIASB,
  output logic                   CIAEB,
  input  logic                   CQAGB,
  input  logic                   CQASB,
  input  logic                   CQAEB
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [2:0] CASC_EQ = 3'b001;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                   state, state_nxt;
  logic [NIBBLES-1:0][3:0]  a_reg, b_reg;
  logic [IW-1:0]            idx;
  logic [2:0]               casc;
  logic [2:0]               cq;
  logic [2:0]               qres;
  logic                     err_stk;
  logic                     err_q;
  logic                     done_q;
  logic                     last;
  logic                     bad;

  assign cq   = {CQAGB, CQASB, CQAEB};
  assign last = (idx == IW'(NIBBLES - 1));
  assign bad  = !((cq == 3'b100) || (cq == 3'b010) || (cq == 3'b001));

  always_ff @(posedge CLK) begin
    if (!RSTn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (START) state_nxt = RUN;
      RUN:  if (last)  state_nxt = IDLE;
      default:         state_nxt = IDLE;
    endcase
  end

  // Slice drive is forced to a neutral "equal" pattern whenever idle.
  always_comb begin
    BUSY = (state == RUN);
    CA   = 4'd0;
    CB   = 4'd0;
    {CIAGB, CIASB, CIAEB} = CASC_EQ;
    if (state == RUN) begin
      CA = a_reg[idx];
      CB = b_reg[idx];
      {CIAGB, CIASB, CIAEB} = casc;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      a_reg   <= '0;
      b_reg   <= '0;
      idx     <= '0;
      casc    <= CASC_EQ;
      err_stk <= 1'b0;
      qres    <= 3'b000;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            a_reg   <= A;
            b_reg   <= B;
            idx     <= '0;
            casc    <= CASC_EQ;
            err_stk <= 1'b0;
          end
        end
        RUN: begin
          casc    <= cq;
          err_stk <= err_stk | bad;
          if (last) begin
            // A corrupted chain anywhere yields an all-zero result with ERR.
            done_q <= 1'b1;
            err_q  <= err_stk | bad;
            qres   <= (err_stk | bad) ? 3'b000 : cq;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign DONE = done_q;
  assign ERR  = err_q;
  assign {QAGB, QASB, QAEB} = qres;

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Bench for cmp_seq_ctrl: behavioural HC85 slice plus a whole-operand reference compare.
module tb_cmp_seq_ctrl;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic          CLK = 1'b0;
  logic          RSTn, START;
  logic [W-1:0]  A, B;
  logic          BUSY, DONE, QAGB, QASB, QAEB, ERR;
  logic [3:0]    CA, CB;
  logic          CIAGB, CIASB, CIAEB;
  logic          CQAGB, CQASB, CQAEB;

  int vec  = 0;
  int errs = 0;
  int tb_nib = 7;
  bit fault_en = 0;

  always #5 CLK = ~CLK;

  cmp_seq_ctrl #(.NIBBLES(N)) dut (
    .CLK(CLK), .RSTn(RSTn), .START(START), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .QAGB(QAGB), .QASB(QASB), .QAEB(QAEB), .ERR(ERR),
    .CA(CA), .CB(CB), .CIAGB(CIAGB), .CIASB(CIASB), .CIAEB(CIAEB),
    .CQAGB(CQAGB), .CQASB(CQASB), .CQAEB(CQAEB)
  );

  // Behavioural 4-bit comparator slice with an optional forced fault on nibble 1.
  always_comb begin
    if (fault_en && tb_nib == 1)  {CQAGB, CQASB, CQAEB} = 3'b110;
    else if (CA > CB)             {CQAGB, CQASB, CQAEB} = 3'b100;
    else if (CA < CB)             {CQAGB, CQASB, CQAEB} = 3'b010;
    else                          {CQAGB, CQASB, CQAEB} = {CIAGB, CIASB, CIAEB};
  end

  function automatic logic [2:0] cmp_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a > b) return 3'b100;
    if (a < b) return 3'b010;
    return 3'b001;
  endfunction

  // Expected cascade into nibble i = compare of the low i nibbles alone.
  function automatic logic [2:0] prefix_ref(input logic [W-1:0] a, input logic [W-1:0] b, input int i);
    logic [W-1:0] m;
    m = (i == 0) ? '0 : ({W{1'b1}} >> (W - 4 * i));
    return cmp_ref(a & m, b & m);
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RSTn = 0; START = 0; A = '0; B = '0;
    step(); step();
    vec++;
    if ({BUSY, DONE, QAGB, QASB, QAEB, ERR} !== 6'b0 || CA !== 4'd0 || CB !== 4'd0 ||
        {CIAGB, CIASB, CIAEB} !== 3'b001) begin
      errs++;
      $display("FAIL reset: busy=%b done=%b q=%b%b%b err=%b ca=%h cb=%h casc=%b%b%b want all 0, casc 001",
               BUSY, DONE, QAGB, QASB, QAEB, ERR, CA, CB, CIAGB, CIASB, CIAEB);
    end
    RSTn = 1;
    step();
  endtask

  // One full compare; operands are scrambled during RUN to show they are latched.
  task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input bit fault, input string nm);
    logic [2:0] exp_q;
    fault_en = fault;
    A = a; B = b; START = 1;
    step();
    START = 0;
    for (int i = 0; i < N; i++) begin
      tb_nib = i;
      A = W'($urandom); B = W'($urandom);
      #1;
      vec++;
      if (BUSY !== 1'b1 || DONE !== 1'b0) begin
        errs++;
        $display("FAIL %s busy nib%0d: busy=%b done=%b want 1/0", nm, i, BUSY, DONE);
      end
      vec++;
      if (CA !== a[4*i +: 4] || CB !== b[4*i +: 4]) begin
        errs++;
        $display("FAIL %s nibble%0d: ca=%h cb=%h want %h %h", nm, i, CA, CB, a[4*i +: 4], b[4*i +: 4]);
      end
      if (!fault || i < 2) begin
        vec++;
        if ({CIAGB, CIASB, CIAEB} !== prefix_ref(a, b, i)) begin
          errs++;
          $display("FAIL %s cascade nib%0d: got %b%b%b want %b", nm, i, CIAGB, CIASB, CIAEB, prefix_ref(a, b, i));
        end
      end
      step();
    end
    tb_nib = 7;
    fault_en = 0;
    exp_q = fault ? 3'b000 : cmp_ref(a, b);
    vec++;
    if (DONE !== 1'b1 || BUSY !== 1'b0 || {QAGB, QASB, QAEB} !== exp_q || ERR !== fault) begin
      errs++;
      $display("FAIL %s result a=%h b=%h: done=%b busy=%b q=%b%b%b err=%b want 1 0 %b %b",
               nm, a, b, DONE, BUSY, QAGB, QASB, QAEB, ERR, exp_q, fault);
    end
    step();
    vec++;
    if (DONE !== 1'b0 || BUSY !== 1'b0 || {QAGB, QASB, QAEB} !== exp_q || ERR !== fault) begin
      errs++;
      $display("FAIL %s hold: done=%b busy=%b q=%b%b%b err=%b want 0 0 %b %b",
               nm, DONE, BUSY, QAGB, QASB, QAEB, ERR, exp_q, fault);
    end
  endtask

  task automatic test_directed();
    run_cmp(16'h1234, 16'h1234, 0, "equal");
    run_cmp(16'h1235, 16'h1234, 0, "lsb_gt");
    run_cmp(16'h0FFF, 16'h1000, 0, "msb_lt");
    run_cmp(16'hFFFF, 16'h0000, 0, "max_min");
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    for (int t = 0; t < 24; t++) begin
      a = W'($urandom);
      case (t % 3)
        0:       b = a;
        1:       b = a ^ (W'($urandom_range(1, 15)) << (4 * $urandom_range(0, N - 1)));
        default: b = W'($urandom);
      endcase
      run_cmp(a, b, 0, "random");
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a0 = '0, b0 = '0, a5 = '0, b5 = '0;
    START = 1;
    for (int e = 0; e < 10; e++) begin
      A = W'($urandom); B = W'($urandom);
      if (e == 3) B = A;
      if (e == 0) begin a0 = A; b0 = B; end
      if (e == 5) begin a5 = A; b5 = B; end
      step();
      vec++;
      if (BUSY !== ((e % 5) != 4) || DONE !== ((e % 5) == 4)) begin
        errs++;
        $display("FAIL b2b edge%0d: busy=%b done=%b want %b %b", e, BUSY, DONE, (e % 5) != 4, (e % 5) == 4);
      end
      if (e == 4 || e == 9) begin
        vec++;
        if ({QAGB, QASB, QAEB} !== cmp_ref(e == 4 ? a0 : a5, e == 4 ? b0 : b5) || ERR !== 1'b0) begin
          errs++;
          $display("FAIL b2b result edge%0d: q=%b%b%b err=%b want %b 0", e, QAGB, QASB, QAEB, ERR,
                   cmp_ref(e == 4 ? a0 : a5, e == 4 ? b0 : b5));
        end
      end
    end
    START = 0;
    step(); step(); step(); step(); step();
  endtask

  task automatic test_mid_reset();
    int seen = 0;
    A = 16'hABCD; B = 16'h1234; START = 1;
    step();
    START = 0;
    step();
    RSTn = 0;
    step();
    vec++;
    if ({BUSY, DONE, QAGB, QASB, QAEB, ERR} !== 6'b0 || CA !== 4'd0 || CB !== 4'd0 ||
        {CIAGB, CIASB, CIAEB} !== 3'b001) begin
      errs++;
      $display("FAIL mid_reset: busy=%b done=%b q=%b%b%b err=%b ca=%h cb=%h want zeros, casc 001",
               BUSY, DONE, QAGB, QASB, QAEB, ERR, CA, CB);
    end
    RSTn = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (DONE === 1'b1 || BUSY === 1'b1) seen++;
    end
    vec++;
    if (seen != 0) begin
      errs++;
      $display("FAIL mid_reset no_done: activity cycles=%0d want 0", seen);
    end
    run_cmp(16'h8000, 16'h7FFF, 0, "after_reset");
  endtask

  task automatic test_fault();
    run_cmp(16'h5A5A, 16'h5A5A, 1, "fault");
    run_cmp(16'h0001, 16'h0002, 0, "fault_clear");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_mid_reset();
    test_fault();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded bound");
    $fatal(1, "timeout");
  end
endmodule
